// File: rtl/bp_pkg.sv
// Types and constants shared by the branch-resolution slice.
package bp_pkg;
  localparam int ADDR_W     = 64;
  localparam int INST_BYTES = 4;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic  valid;
    addr_t pc;
    logic  pred_taken;
    addr_t pred_target;
  } pred_entry_t;
endpackage

// File: rtl/branch_resolve_unit_if.sv
// Prediction, EXE-outcome, redirect and predictor-update signals of the resolve unit.
interface branch_resolve_unit_if #(parameter int ADDR_WIDTH = 64);
  logic                  if_valid;
  logic [ADDR_WIDTH-1:0] pc_if;
  logic                  jump_if;
  logic [ADDR_WIDTH-1:0] pc_target_if;
  logic                  exe_is_jump;
  logic                  exe_taken;
  logic [ADDR_WIDTH-1:0] exe_target;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  upd_valid;
  logic [ADDR_WIDTH-1:0] upd_pc;
  logic [ADDR_WIDTH-1:0] upd_target;
  logic                  upd_taken;

  modport master (
    output if_valid, pc_if, jump_if, pc_target_if, exe_is_jump, exe_taken, exe_target,
    input  redirect_valid, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken
  );

  modport slave (
    input  if_valid, pc_if, jump_if, pc_target_if, exe_is_jump, exe_taken, exe_target,
    output redirect_valid, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken
  );
endinterface

// File: rtl/branch_resolve_unit_sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      count <= '0;
    else if (en && (count != '1)) count <= count + 1'b1;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks fetch-time predictions to EXE, resolves them, redirects fetch on
// mispredict, feeds the predictor update port and keeps statistics.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  branch_resolve_unit_if.slave  bus,
  output logic [CNT_WIDTH-1:0]  branch_cnt,
  output logic [CNT_WIDTH-1:0]  mispred_cnt,
  output logic [ADDR_WIDTH-1:0] exe_pc
);
  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_target;
  } entry_t;

  entry_t                if_id, id_exe;
  logic                  resolve, taken_jump, mispredict, redirect, update;
  logic [ADDR_WIDTH-1:0] next_pc;

  // Flush only clears valid; the stale pc/pred fields are never consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id  <= '0;
      id_exe <= '0;
    end else if (!stall) begin
      if (redirect) begin
        if_id.valid  <= 1'b0;
        id_exe.valid <= 1'b0;
      end else begin
        if_id  <= '{valid: bus.if_valid, pc: bus.pc_if,
                    pred_taken: bus.jump_if, pred_target: bus.pc_target_if};
        id_exe <= if_id;
      end
    end
  end

  always_comb begin
    resolve    = id_exe.valid & ~stall;
    taken_jump = bus.exe_is_jump & bus.exe_taken;
    next_pc    = taken_jump ? bus.exe_target : id_exe.pc + ADDR_WIDTH'(INST_BYTES);
    // A non-branch predicted taken is a predictor alias and must be undone.
    if (bus.exe_is_jump)
      mispredict = (id_exe.pred_taken != bus.exe_taken) |
                   (taken_jump & id_exe.pred_taken & (id_exe.pred_target != bus.exe_target));
    else
      mispredict = id_exe.pred_taken;
    redirect = resolve & mispredict;
    update   = resolve & bus.exe_is_jump;
  end

  assign bus.redirect_valid = redirect;
  assign bus.redirect_pc    = resolve ? next_pc : '0;
  assign bus.upd_valid      = update;
  assign bus.upd_pc         = update ? id_exe.pc : '0;
  assign bus.upd_target     = update ? bus.exe_target : '0;
  assign bus.upd_taken      = update & bus.exe_taken;
  assign exe_pc             = id_exe.pc;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk(clk), .rst(rst), .en(update), .count(branch_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_mispred_cnt (
    .clk(clk), .rst(rst), .en(redirect), .count(mispred_cnt)
  );
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Consumer end of the branch-prediction interface.
- Carries each fetched instruction's prediction (taken flag, target) from IF through ID to EXE.
- Compares it against the actual outcome computed in EXE.
- On mismatch, issues a redirect PC and flushes the younger stages.
- Drives the predictor's update port and keeps branch/misprediction statistics.
- Sits between the fetch-stage predictor and the EXE-stage branch unit.

Parameters:
ADDR_WIDTH, 64, PC/target width
CNT_WIDTH, 32, width of the statistics counters

Ports:
clk  in  1  clock
rst  in  1  reset (asynchronous, active-high)
stall  in  1  pipeline stall; holds both tracking registers and blocks all resolution effects
if_valid  in  1  IF holds a real instruction this cycle
pc_if  in  ADDR_WIDTH  IF PC
jump_if  in  1  predictor says taken
pc_target_if  in  ADDR_WIDTH  predicted target
exe_is_jump  in  1  instruction in EXE is a branch/jump
exe_taken  in  1  actual direction
exe_target  in  ADDR_WIDTH  actual target
redirect_valid  out  1  fetch must restart at redirect_pc
redirect_pc  out  ADDR_WIDTH  corrected fetch PC
upd_valid  out  1  predictor update strobe
upd_pc  out  ADDR_WIDTH  PC of the resolved branch
upd_target  out  ADDR_WIDTH  actual target
upd_taken  out  1  actual direction
branch_cnt  out  CNT_WIDTH  resolved branches
mispred_cnt  out  CNT_WIDTH  redirects issued
exe_pc  out  ADDR_WIDTH  tracked PC of the instruction in EXE (debug/commit)

Behaviour:
- Two tracking registers, IF/ID and ID/EXE. Each entry is {valid, pc, pred_taken, pred_target}.
- Reset: all entry fields 0, counters 0. Outputs after reset: redirect_valid=0, upd_valid=0, redirect_pc=0, upd_*=0, exe_pc=0.
- Per posedge, in priority order:
  - rst: clear everything.
  - stall=1: hold both entries and both counters.
  - redirect_valid=1: clear valid in both entries; pc/pred fields don't-care. Flush dominates the load path.
  - Otherwise: IF/ID <= {if_valid, pc_if, jump_if, pc_target_if}; ID/EXE <= IF/ID.
- EXE resolution is combinational from ID/EXE plus the exe_* inputs; let E = ID/EXE.valid & !stall.
  - Actual next PC: exe_target if exe_is_jump & exe_taken, else E.pc+4, computed modulo 2^ADDR_WIDTH.
  - Mispredict when any of the following holds:
    - exe_is_jump and pred_taken != exe_taken;
    - exe_is_jump, exe_taken, pred_taken and pred_target != exe_target;
    - !exe_is_jump and pred_taken (alias hit).
  - redirect_valid = E & mispredict; redirect_pc = actual next PC whenever E, else 0.
  - A correct prediction, including correctly predicted not-taken, produces no redirect.
- Predictor update: upd_valid = E & exe_is_jump, with upd_pc=ID/EXE.pc, upd_target=exe_target, upd_taken=exe_taken. Outputs are 0 when upd_valid=0. Same-cycle combinational, so the predictor's edge captures it.
- Counters: branch_cnt += 1 on upd_valid; mispred_cnt += 1 on redirect_valid. Both saturate at all-ones and never wrap.
- exe_pc = ID/EXE.pc.
- Latency:
  - A prediction presented in IF at cycle t resolves in cycle t+2 when there are no stalls.
  - The redirect flushes at edge t+2→t+3; the IF instruction in cycle t+3 is fetched from redirect_pc and must be supplied by fetch.
- Boundary cases:
  - Invalid entries (bubbles) never redirect, update or count, regardless of pred/exe inputs.
  - Stall asserted in the same cycle as a mispredict: redirect is suppressed and re-evaluated when stall drops.
  - Back-to-back mispredicts are impossible, because the flush invalidates ID/EXE.
  - Reset mid-stream drops all in-flight entries and returns the outputs to their reset values immediately (asynchronous).

Decomposition:
- Shared package bp_pkg holds:
  - addr_t, typedef of logic[ADDR_WIDTH-1:0];
  - pred_entry_t, struct {valid, pc, pred_taken, pred_target};
  - constant INST_BYTES=4.
- Natural sub-module: sat_counter, a parameterized saturating counter with enable, instantiated twice for the statistics.

Test Plan:
- Reset, then check outputs: rst pulse → redirect_valid=0, upd_valid=0, branch_cnt=0, mispred_cnt=0, exe_pc=0.
- Correct taken prediction:
  - Stimulus: pc_if=0x100, jump_if=1, pc_target_if=0x200, if_valid=1; two cycles later exe_is_jump=1, exe_taken=1, exe_target=0x200.
  - Required: redirect_valid=0; upd_valid=1 with upd_pc=0x100; branch_cnt=1; mispred_cnt=0.
- Direction mispredict:
  - Stimulus: pc_if=0x104, jump_if=0; in EXE exe_is_jump=1, exe_taken=1, exe_target=0x40.
  - Required: redirect_valid=1, redirect_pc=0x40; next cycle both entries invalid (no upd_valid for two cycles); mispred_cnt=1.
- Alias mispredict:
  - Stimulus: pc_if=0x300, jump_if=1, pc_target_if=0x500; in EXE exe_is_jump=0.
  - Required: redirect_valid=1, redirect_pc=0x304, upd_valid=0, branch_cnt unchanged.
- Stall during mispredict:
  - Stimulus: as the direction-mispredict case, with stall=1 for 3 cycles at resolution.
  - Required: redirect_valid=0 and exe_pc held at 0x104 during the stall; redirect fires on the first cycle with stall=0; counters count once.
- Saturation:
  - Stimulus: preload CNT_WIDTH=4 build; 20 resolved branches.
  - Required: branch_cnt=15 and it stays at 15.
